// File: rtl/marker_tracker.sv
// Colored-marker bounding-extreme tracker: classifies each pixel against an RGB threshold
// and, at every frame end, publishes the leftmost/rightmost/topmost/bottommost matches.
module marker_tracker #(
    parameter logic [10:0] H_ACTIVE  = 11'd640,
    parameter logic [10:0] V_ACTIVE  = 11'd480,
    parameter logic [7:0]  R_MIN     = 8'd160,
    parameter logic [7:0]  G_MAX     = 8'd80,
    parameter logic [7:0]  B_MAX     = 8'd80,
    parameter logic [19:0] MIN_COUNT = 20'd16,
    parameter logic [10:0] NOT_FOUND = 11'd2023
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [10:0]      i_x,
    input  logic [10:0]      i_y,
    input  logic [2:0][7:0]  i_rgb,
    input  logic             i_frame_end,
    output logic             predict_valid,
    output logic [1:0][10:0] left,
    output logic [1:0][10:0] right,
    output logic [1:0][10:0] up,
    output logic [1:0][10:0] down,
    output logic [19:0]      o_count
);

    typedef enum logic {
        S_SYNC,
        S_ACCUM
    } state_e;

    localparam logic [19:0] CNT_MAX = 20'hFFFFF;

    state_e state_q, state_d;

    logic        pixMatch;
    logic        s1Match_q;
    logic [10:0] s1X_q;
    logic [10:0] s1Y_q;
    logic        s1FrameEnd_q;

    logic [19:0]      cnt_q, cnt_d;
    logic [1:0][10:0] trkLeft_q, trkLeft_d;
    logic [1:0][10:0] trkRight_q, trkRight_d;
    logic [1:0][10:0] trkUp_q, trkUp_d;
    logic [1:0][10:0] trkDown_q, trkDown_d;

    logic [19:0]      cntMerged;
    logic [1:0][10:0] leftMerged, rightMerged, upMerged, downMerged;

    logic             pv_q, pv_d;
    logic [19:0]      repCount_q, repCount_d;
    logic [1:0][10:0] repLeft_q, repLeft_d;
    logic [1:0][10:0] repRight_q, repRight_d;
    logic [1:0][10:0] repUp_q, repUp_d;
    logic [1:0][10:0] repDown_q, repDown_d;

    assign pixMatch = i_valid
                    && (i_x < H_ACTIVE) && (i_y < V_ACTIVE)
                    && (i_rgb[0] >= R_MIN)
                    && (i_rgb[1] <= G_MAX)
                    && (i_rgb[2] <= B_MAX);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1Match_q    <= 1'b0;
            s1X_q        <= '0;
            s1Y_q        <= '0;
            s1FrameEnd_q <= 1'b0;
        end else begin
            s1Match_q    <= pixMatch;
            s1X_q        <= i_x;
            s1Y_q        <= i_y;
            s1FrameEnd_q <= i_frame_end;
        end
    end

    // Fold the stage-1 pixel into the trackers; a zero count means this is the frame's first match.
    always_comb begin
        cntMerged   = cnt_q;
        leftMerged  = trkLeft_q;
        rightMerged = trkRight_q;
        upMerged    = trkUp_q;
        downMerged  = trkDown_q;
        if (s1Match_q) begin
            cntMerged = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 20'd1;
            if (cnt_q == '0) begin
                leftMerged  = {s1Y_q, s1X_q};
                rightMerged = {s1Y_q, s1X_q};
                upMerged    = {s1Y_q, s1X_q};
                downMerged  = {s1Y_q, s1X_q};
            end else begin
                if (s1X_q < trkLeft_q[0])  leftMerged  = {s1Y_q, s1X_q};
                if (s1X_q > trkRight_q[0]) rightMerged = {s1Y_q, s1X_q};
                if (s1Y_q < trkUp_q[1])    upMerged    = {s1Y_q, s1X_q};
                if (s1Y_q > trkDown_q[1])  downMerged  = {s1Y_q, s1X_q};
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        trkLeft_d  = trkLeft_q;
        trkRight_d = trkRight_q;
        trkUp_d    = trkUp_q;
        trkDown_d  = trkDown_q;
        pv_d       = 1'b0;
        repCount_d = repCount_q;
        repLeft_d  = repLeft_q;
        repRight_d = repRight_q;
        repUp_d    = repUp_q;
        repDown_d  = repDown_q;
        case (state_q)
            // The first frame after reset is partial, so its end only arms accumulation.
            S_SYNC: begin
                if (s1FrameEnd_q) begin
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (s1FrameEnd_q) begin
                    pv_d       = 1'b1;
                    repCount_d = cntMerged;
                    if (cntMerged >= MIN_COUNT) begin
                        repLeft_d  = leftMerged;
                        repRight_d = rightMerged;
                        repUp_d    = upMerged;
                        repDown_d  = downMerged;
                    end else begin
                        repLeft_d  = {NOT_FOUND, NOT_FOUND};
                        repRight_d = {NOT_FOUND, NOT_FOUND};
                        repUp_d    = {NOT_FOUND, NOT_FOUND};
                        repDown_d  = {NOT_FOUND, NOT_FOUND};
                    end
                    cnt_d      = '0;
                    trkLeft_d  = '0;
                    trkRight_d = '0;
                    trkUp_d    = '0;
                    trkDown_d  = '0;
                end else begin
                    cnt_d      = cntMerged;
                    trkLeft_d  = leftMerged;
                    trkRight_d = rightMerged;
                    trkUp_d    = upMerged;
                    trkDown_d  = downMerged;
                end
            end
            default: begin
                state_d = S_SYNC;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_SYNC;
            cnt_q      <= '0;
            trkLeft_q  <= '0;
            trkRight_q <= '0;
            trkUp_q    <= '0;
            trkDown_q  <= '0;
            pv_q       <= 1'b0;
            repCount_q <= '0;
            repLeft_q  <= {NOT_FOUND, NOT_FOUND};
            repRight_q <= {NOT_FOUND, NOT_FOUND};
            repUp_q    <= {NOT_FOUND, NOT_FOUND};
            repDown_q  <= {NOT_FOUND, NOT_FOUND};
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            trkLeft_q  <= trkLeft_d;
            trkRight_q <= trkRight_d;
            trkUp_q    <= trkUp_d;
            trkDown_q  <= trkDown_d;
            pv_q       <= pv_d;
            repCount_q <= repCount_d;
            repLeft_q  <= repLeft_d;
            repRight_q <= repRight_d;
            repUp_q    <= repUp_d;
            repDown_q  <= repDown_d;
        end
    end

    assign predict_valid = pv_q;
    assign o_count       = repCount_q;
    assign left          = repLeft_q;
    assign right         = repRight_q;
    assign up            = repUp_q;
    assign down          = repDown_q;

endmodule

// File: tb/tb_marker_tracker.sv
// Scoreboard bench for marker_tracker: a reference model queues the expected report at each
// driven frame end, and a monitor pops and compares whenever predict_valid pulses.
module tb_marker_tracker;

    localparam logic [10:0] NF = 11'd2023;

    typedef struct {
        logic [10:0] lx, ly, rx, ry, ux, uy, dx, dy;
        logic [19:0] cnt;
        int          due;
    } rep_t;

    logic             i_clk = 1'b0;
    logic             i_rst = 1'b1;
    logic             i_valid = 1'b0;
    logic [10:0]      i_x = '0;
    logic [10:0]      i_y = '0;
    logic [2:0][7:0]  i_rgb = '0;
    logic             i_frame_end = 1'b0;
    logic             predict_valid;
    logic [1:0][10:0] left, right, up, down;
    logic [19:0]      o_count;

    int testsRun = 0;
    int testsFailed = 0;
    int cycleCount = 0;

    rep_t sbQueue[$];

    int  mCnt = 0;
    bit  mSynced = 1'b0;
    int  mLx, mLy, mRx, mRy, mUx, mUy, mDx, mDy;

    marker_tracker dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_valid      (i_valid),
        .i_x          (i_x),
        .i_y          (i_y),
        .i_rgb        (i_rgb),
        .i_frame_end  (i_frame_end),
        .predict_valid(predict_valid),
        .left         (left),
        .right        (right),
        .up           (up),
        .down         (down),
        .o_count      (o_count)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one pixel cycle and advance the reference model in the same raster order.
    task automatic applyStimulus(input bit valid, input int x, input int y,
                                 input int r, input int g, input int b, input bit fe);
        rep_t e;
        bit   match;
        @(negedge i_clk);
        i_valid     = valid;
        i_x         = 11'(x);
        i_y         = 11'(y);
        i_rgb[0]    = 8'(r);
        i_rgb[1]    = 8'(g);
        i_rgb[2]    = 8'(b);
        i_frame_end = fe;
        match = valid && x < 640 && y < 480 && r >= 160 && g <= 80 && b <= 80;
        if (match) begin
            if (mCnt == 0) begin
                mLx = x; mLy = y; mRx = x; mRy = y;
                mUx = x; mUy = y; mDx = x; mDy = y;
            end else begin
                if (x < mLx) begin mLx = x; mLy = y; end
                if (x > mRx) begin mRx = x; mRy = y; end
                if (y < mUy) begin mUx = x; mUy = y; end
                if (y > mDy) begin mDx = x; mDy = y; end
            end
            if (mCnt < 20'hFFFFF) mCnt++;
        end
        if (fe) begin
            if (mSynced) begin
                e.cnt = 20'(mCnt);
                e.due = cycleCount + 2;
                if (mCnt >= 16) begin
                    e.lx = 11'(mLx); e.ly = 11'(mLy); e.rx = 11'(mRx); e.ry = 11'(mRy);
                    e.ux = 11'(mUx); e.uy = 11'(mUy); e.dx = 11'(mDx); e.dy = 11'(mDy);
                end else begin
                    e.lx = NF; e.ly = NF; e.rx = NF; e.ry = NF;
                    e.ux = NF; e.uy = NF; e.dx = NF; e.dy = NF;
                end
                sbQueue.push_back(e);
            end
            mSynced = 1'b1;
            mCnt = 0;
        end
    endtask

    // Raster over [x0..x1]x[y0..y1]; pixels inside the block are pure red, others black.
    task automatic applyFrame(input int x0, input int x1, input int y0, input int y1,
                              input int bx0, input int bx1, input int by0, input int by1,
                              input bit endFrame);
        for (int y = y0; y <= y1; y++) begin
            for (int x = x0; x <= x1; x++) begin
                bit red;
                red = (x >= bx0 && x <= bx1 && y >= by0 && y <= by1);
                applyStimulus(1'b1, x, y, red ? 255 : 0, 0, 0,
                              endFrame && x == x1 && y == y1);
            end
        end
    endtask

    task automatic waitDrain(input string tag);
        for (int i = 0; i < 20 && sbQueue.size() != 0; i++) begin
            applyStimulus(1'b0, 0, 0, 0, 0, 0, 1'b0);
            #1;
        end
        applyStimulus(1'b0, 0, 0, 0, 0, 0, 1'b0);
        #1;
        checkOutput(tag, sbQueue.size(), 0);
    endtask

    task automatic applyReset(input int mode);
        @(negedge i_clk);
        i_rst = 1'b1;
        i_valid = 1'b0;
        i_frame_end = 1'b0;
        repeat (2) @(negedge i_clk);
        checkOutput("rst_pv", predict_valid, 0);
        checkOutput("rst_left_x", left[0], NF);
        checkOutput("rst_left_y", left[1], NF);
        checkOutput("rst_right_x", right[0], NF);
        checkOutput("rst_up_y", up[1], NF);
        checkOutput("rst_down_x", down[0], NF);
        checkOutput("rst_down_y", down[1], NF);
        checkOutput("rst_count", o_count, 0);
        i_rst = 1'b0;
        mCnt = 0;
        mSynced = 1'b0;
        if (mode != 0) sbQueue.delete();
    endtask

    // Every pulse must match the oldest queued report, arriving exactly two cycles after its frame end.
    always @(negedge i_clk) begin
        if (!i_rst && predict_valid === 1'b1) begin
            if (sbQueue.size() == 0) begin
                checkOutput("unexpected_pulse", 1, 0);
            end else begin
                rep_t e;
                e = sbQueue.pop_front();
                checkOutput("latency", cycleCount, e.due);
                checkOutput("left_x", left[0], e.lx);
                checkOutput("left_y", left[1], e.ly);
                checkOutput("right_x", right[0], e.rx);
                checkOutput("right_y", right[1], e.ry);
                checkOutput("up_x", up[0], e.ux);
                checkOutput("up_y", up[1], e.uy);
                checkOutput("down_x", down[0], e.dx);
                checkOutput("down_y", down[1], e.dy);
                checkOutput("count", o_count, e.cnt);
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        applyReset(0);

        // Frame 0 is partial after reset and must not report.
        applyFrame(0, 7, 0, 3, 0, 7, 0, 3, 1'b1);
        waitDrain("drain_frame0");

        applyFrame(98, 106, 199, 205, 100, 104, 200, 204, 1'b1);
        waitDrain("drain_5x5");
        checkOutput("c5_left_x", left[0], 100);
        checkOutput("c5_left_y", left[1], 200);
        checkOutput("c5_right_x", right[0], 104);
        checkOutput("c5_right_y", right[1], 200);
        checkOutput("c5_up_x", up[0], 100);
        checkOutput("c5_up_y", up[1], 200);
        checkOutput("c5_down_x", down[0], 100);
        checkOutput("c5_down_y", down[1], 204);
        checkOutput("c5_count", o_count, 25);
        checkOutput("c5_pv_one_cycle", predict_valid, 0);

        applyFrame(10, 14, 10, 14, 11, 13, 11, 13, 1'b1);
        waitDrain("drain_3x3");
        checkOutput("c3_left_x", left[0], NF);
        checkOutput("c3_down_y", down[1], NF);
        checkOutput("c3_count", o_count, 9);

        for (int i = 0; i < 20; i++) applyStimulus(1'b1, i, 50, 160, 80, 80, 1'b0);
        for (int i = 0; i < 5; i++)  applyStimulus(1'b1, i, 51, 159, 0, 0, 1'b0);
        for (int i = 0; i < 5; i++)  applyStimulus(1'b1, i, 52, 255, 81, 0, 1'b0);
        for (int i = 0; i < 3; i++)  applyStimulus(1'b1, i, 53, 255, 0, 81, 1'b0);
        for (int i = 0; i < 3; i++)  applyStimulus(1'b1, 640 + i, 54, 255, 0, 0, 1'b0);
        applyStimulus(1'b1, 5, 480, 255, 0, 0, 1'b0);
        applyStimulus(1'b0, 6, 55, 255, 0, 0, 1'b0);
        applyStimulus(1'b0, 0, 0, 0, 0, 0, 1'b1);
        waitDrain("drain_thresh");
        checkOutput("th_count", o_count, 20);
        checkOutput("th_right_x", right[0], 19);

        applyFrame(0, 15, 10, 10, 0, 15, 10, 10, 1'b0);
        applyStimulus(1'b1, 639, 479, 255, 0, 0, 1'b1);
        waitDrain("drain_lastpix");
        checkOutput("lp_right_x", right[0], 639);
        checkOutput("lp_right_y", right[1], 479);
        checkOutput("lp_down_x", down[0], 639);
        checkOutput("lp_down_y", down[1], 479);
        checkOutput("lp_count", o_count, 17);

        applyFrame(0, 19, 5, 5, 0, 19, 5, 5, 1'b1);
        applyStimulus(1'b0, 0, 0, 0, 0, 0, 1'b1);
        applyFrame(0, 16, 6, 6, 0, 16, 6, 6, 1'b1);
        waitDrain("drain_b2b");
        checkOutput("b2b_count", o_count, 17);
        checkOutput("b2b_left_y", left[1], 6);

        for (int i = 0; i < 10; i++) applyStimulus(1'b1, i, 30, 255, 0, 0, 1'b0);
        applyReset(1);
        applyFrame(0, 19, 2, 2, 0, 19, 2, 2, 1'b1);
        waitDrain("drain_after_rst");
        checkOutput("mr_count_held", o_count, 0);
        applyFrame(0, 17, 3, 3, 0, 17, 3, 3, 1'b1);
        waitDrain("drain_mr_full");
        checkOutput("mr_count", o_count, 18);
        checkOutput("mr_right_x", right[0], 17);

        checkOutput("pending", sbQueue.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
